// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/SSbar/MOSI on clk, shifts words MSB-first in any
// CPOL/CPHA mode, and supplies response words from a one-entry TX holding buffer.
module spi_slave #(
    parameter int         WORD_LENGTH = 8,
    parameter logic [1:0] SPI_MODE    = 2'b00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SCLK,
    input  logic                   SSbar,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic                   MISO_EN,
    input  logic                   tx_valid,
    input  logic [WORD_LENGTH-1:0] TX_DATA,
    output logic                   tx_ready,
    output logic [WORD_LENGTH-1:0] RDATA,
    output logic                   rx_valid,
    output logic                   tx_underrun
);

    localparam logic CPOL  = SPI_MODE[1];
    localparam logic CPHA  = SPI_MODE[0];
    localparam int   CNT_W = $clog2(WORD_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync_reg, ss_sync_reg, mosi_sync_reg;
    logic                   sclk_prev_reg, ss_prev_reg;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge, ss_fall, ss_rise;

    logic                   start, stop, do_sample, do_shift, complete, load;
    logic [WORD_LENGTH-1:0] load_word;

    logic [WORD_LENGTH-1:0] buf_data_reg;
    logic                   buf_full_reg;
    logic [WORD_LENGTH-1:0] tx_shift_reg, rx_shift_reg, rx_word;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic                   accept;

    // Synchroniser chains; idle levels are chosen so that reset release creates no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_reg <= {SYNC_STAGES{CPOL}};
            ss_sync_reg   <= {SYNC_STAGES{1'b1}};
            mosi_sync_reg <= '0;
            sclk_prev_reg <= CPOL;
            ss_prev_reg   <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
            ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], SSbar};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
            sclk_prev_reg <= sclk_s;
            ss_prev_reg   <= ss_s;
        end
    end

    assign sclk_s      = sclk_sync_reg[SYNC_STAGES-1];
    assign ss_s        = ss_sync_reg[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_reg[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_prev_reg;
    assign sclk_fall   = ~sclk_s & sclk_prev_reg;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall     = ~ss_s & ss_prev_reg;
    assign ss_rise     = ss_s & ~ss_prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        stop       = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign complete  = do_sample && (bit_cnt_reg == LAST_BIT);
    assign load      = start | complete;
    assign load_word = buf_full_reg ? buf_data_reg : '0;
    assign accept    = tx_valid & ~buf_full_reg;
    assign rx_word   = {rx_shift_reg[WORD_LENGTH-2:0], mosi_s};
    assign tx_ready  = ~buf_full_reg;

    // A write in the same cycle as a load lands in the buffer after the load took the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data_reg <= '0;
            buf_full_reg <= 1'b0;
        end else if (accept) begin
            buf_data_reg <= TX_DATA;
            buf_full_reg <= 1'b1;
        end else if (load) begin
            buf_full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
            RDATA        <= '0;
            rx_valid     <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            rx_valid    <= complete;
            tx_underrun <= load & ~buf_full_reg;
            if (start || stop) begin
                bit_cnt_reg <= '0;
            end else if (do_sample) begin
                rx_shift_reg <= rx_word;
                bit_cnt_reg  <= complete ? '0 : bit_cnt_reg + 1'b1;
                if (complete) RDATA <= rx_word;
            end
        end
    end

    // With CPHA=0 the MSB must already be on MISO before the first leading edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_reg <= '0;
            MISO         <= 1'b0;
            MISO_EN      <= 1'b0;
        end else if (stop) begin
            MISO    <= 1'b0;
            MISO_EN <= 1'b0;
        end else if (start) begin
            MISO_EN <= 1'b1;
            if (!CPHA) begin
                MISO         <= load_word[WORD_LENGTH-1];
                tx_shift_reg <= load_word << 1;
            end else begin
                tx_shift_reg <= load_word;
            end
        end else if (complete) begin
            tx_shift_reg <= load_word;
        end else if (do_shift) begin
            MISO         <= tx_shift_reg[WORD_LENGTH-1];
            tx_shift_reg <= tx_shift_reg << 1;
        end
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI slave endpoint that answers the team's spi_master across the SCLK/MOSI/MISO/SSbar link. SCLK, SSbar and MOSI are oversampled on the local clk, the word is shifted in and out MSB-first in any of the four CPOL/CPHA modes, and each completed word is handed to the local side. A one-entry TX holding buffer with a valid/ready handshake supplies the response word. It sits on the peripheral side of the link as the counterpart of spi_master.

Parameters:
WORD_LENGTH, 8, bits per SPI word (matches `WORD_LENGTH).
SPI_MODE, 2'b00, {CPOL,CPHA} encoding (same encoding as `MODE_POL_PHS_xx).
SYNC_STAGES, 2, flip-flop stages on SCLK, SSbar and MOSI (minimum 2).

Ports:
clk  input  1  system clock; the only clock in the block.
rst  input  1  reset, asynchronous, active-high.
SCLK  input  1  SPI clock from master, asynchronous to clk.
SSbar  input  1  slave select, active-low, asynchronous.
MOSI  input  1  master-out data, asynchronous.
MISO  output  1  slave-out data.
MISO_EN  output  1  MISO drive enable; high only while selected.
tx_valid  input  1  TX_DATA is offered.
TX_DATA  input  WORD_LENGTH  response word.
tx_ready  output  1  holding buffer is empty.
RDATA  output  WORD_LENGTH  last received word, held until the next word completes.
rx_valid  output  1  one-cycle pulse when RDATA updates.
tx_underrun  output  1  one-cycle pulse when a word starts with the buffer empty.

Behaviour:
- Reset values: MISO=0, MISO_EN=0, tx_ready=1, RDATA=0, rx_valid=0, tx_underrun=0, FSM in IDLE, bit counter=0. Reset mid-word aborts the word immediately. Nothing is delivered and the buffer is cleared.
- Synchronisation: SCLK, SSbar and MOSI each pass through SYNC_STAGES flops. Edges are detected on synced SCLK against its previous value. Leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- Timing requirement on the master: SCLK half-period >= SYNC_STAGES+2 clk cycles.
- TX buffer:
  - Accepts a word when tx_valid & tx_ready. tx_ready drops in the next cycle.
  - The buffer empties (tx_ready=1 next cycle) when its contents are loaded into the shift register.
  - tx_valid while tx_ready=0 is ignored and the existing contents are kept.
- FSM states: IDLE, ACTIVE.
- IDLE -> ACTIVE on a synced SSbar falling edge:
  - The shift register loads from the buffer if it is full. Otherwise it loads all zeros and tx_underrun pulses.
  - bit counter is set to 0 and MISO_EN=1.
  - If CPHA=0, MISO is driven with the MSB in the same cycle.
- ACTIVE, sample edge: the synced MOSI bit is shifted into the RX shift register LSB and the bit counter increments.
- ACTIVE, shift edge: MISO is driven with the next TX bit. If CPHA=1, the first leading edge drives the MSB.
- Word completion (sample that makes counter = WORD_LENGTH):
  - RDATA <= assembled word and rx_valid pulses for 1 cycle. Latency is SYNC_STAGES+1 clk cycles from the raw SCLK sample edge.
  - The counter wraps to 0 and the TX shift register reloads from the buffer (or zeros plus a tx_underrun pulse), so back-to-back words run without deasserting SSbar.
  - CPHA=0: the next shift edge drives the new MSB.
- ACTIVE -> IDLE on synced SSbar rising:
  - A partial word (counter != 0) is discarded. No rx_valid, and RDATA is unchanged.
  - MISO_EN=0 and MISO=0 in the next cycle.
  - An unconsumed buffer word is kept for the next selection.
- SCLK edges while in IDLE are ignored.
- Simultaneous events: if a buffer write coincides with a load, the load takes the old contents (or zeros if the buffer was empty) and the new word is accepted into the buffer.
- rx_valid has no back-pressure. The local side must capture RDATA before the next word completes.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), buffer preloaded with 0x3C, master sends 0xA5 -> MISO sequence 0,0,1,1,1,1,0,0 sampled on rising edges; RDATA=0xA5 with a single rx_valid pulse; tx_ready returns to 1 at selection.
- Mode 3 (CPOL=1, CPHA=1), TX=0x81, master sends 0x5A -> MISO changes on falling edges and carries 0x81; RDATA=0x5A; MISO_EN drops after SSbar rises.
- Back-to-back: TX words 0x11 then 0x22 written in handshake, 16 SCLK cycles under one SSbar, MOSI 0xF0 then 0x0F -> two rx_valid pulses with RDATA 0xF0 then 0x0F; MISO carries 0x11 then 0x22.
- Abort: SSbar deasserted after 5 SCLK cycles of 0xFF, then a full new word 0x33 -> no rx_valid for the partial word, RDATA becomes 0x33 only, bit counter restarts at 0.
- Underrun: select with the buffer empty -> tx_underrun pulses once, MISO is all zeros, and reception still yields correct RDATA.
- Reset mid-word: assert rst after 3 bits -> all outputs return to their reset values asynchronously; after release, a full 0xC3 transfer completes correctly.
